button_step_counter: RTL

Parametrised successor of the board-level push-button up/down counter with LED display. Two raw push-buttons are synchronised, debounced and edge-detected, with optional auto-repeat while held. They step a CNT_W-bit counter in wrap or saturate mode, and the counter drives LED_W LEDs in a runtime-selectable display mode. The block sits directly behind the board KEY inputs and in front of the LED pins.

---
 rtl/button_step_counter.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/button_step_counter.sv
// Two debounced push-buttons with press auto-repeat step a CNT_W-bit up/down counter,
// whose value drives LED_W LEDs in a runtime-selectable display mode.
module button_step_counter #(
  parameter int CNT_W           = 3,
  parameter int LED_W           = 8,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 5000000,
  parameter int SATURATE        = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc_button,
  input  logic             dec_button,
  input  logic [1:0]       mode,
  output logic [CNT_W-1:0] count,
  output logic [LED_W-1:0] LEDS,
  output logic             at_min,
  output logic             at_max
);

  localparam int DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int T_MAX   = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int T_W     = (T_MAX > 1) ? $clog2(T_MAX) : 1;
  localparam int DB_LAST = DEBOUNCE_CYCLES - 1;
  localparam int RD_LAST = (REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0;
  localparam int RR_LAST = REPEAT_RATE - 1;
  localparam bit SAT     = (SATURATE != 0);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_REPEAT} state_t;

  logic [1:0] w_raw;
  logic [1:0] w_step;

  assign w_raw = {dec_button, inc_button};

  for (genvar g = 0; g < 2; g++) begin : g_btn
    logic            r_s1, r_s2, r_db, r_armed, r_step;
    logic [DB_W-1:0] r_db_cnt;
    logic [T_W-1:0]  r_timer;
    state_t          r_state;
    logic            w_ref, w_db_done, w_db_next;

    // Until armed, the debouncer waits for a stable low so a button held through reset is ignored.
    assign w_ref     = r_armed ? r_db : 1'b1;
    assign w_db_done = (r_s2 != w_ref) && (r_db_cnt == DB_W'(DB_LAST));
    assign w_db_next = (w_db_done && r_armed) ? r_s2 : r_db;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_s1     <= 1'b0;
        r_s2     <= 1'b0;
        r_db     <= 1'b0;
        r_armed  <= 1'b0;
        r_db_cnt <= '0;
      end else begin
        r_s1 <= w_raw[g];
        r_s2 <= r_s1;
        r_db <= w_db_next;
        if (w_db_done) begin
          r_db_cnt <= '0;
          r_armed  <= 1'b1;
        end else if (r_s2 != w_ref) begin
          r_db_cnt <= r_db_cnt + 1'b1;
        end else begin
          r_db_cnt <= '0;
        end
      end
    end

    // The step is registered on the same edge that db rises, so it is visible while db is high.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_state <= ST_IDLE;
        r_timer <= '0;
        r_step  <= 1'b0;
      end else begin
        r_step <= 1'b0;
        case (r_state)
          ST_IDLE: begin
            r_timer <= '0;
            if (w_db_next && !r_db) begin
              r_step <= 1'b1;
              if (REPEAT_DELAY > 0) r_state <= ST_WAIT;
            end
          end
          ST_WAIT: begin
            if (!w_db_next) begin
              r_state <= ST_IDLE;
              r_timer <= '0;
            end else if (r_timer == T_W'(RD_LAST)) begin
              r_step  <= 1'b1;
              r_timer <= '0;
              r_state <= ST_REPEAT;
            end else begin
              r_timer <= r_timer + 1'b1;
            end
          end
          ST_REPEAT: begin
            if (!w_db_next) begin
              r_state <= ST_IDLE;
              r_timer <= '0;
            end else if (r_timer == T_W'(RR_LAST)) begin
              r_step  <= 1'b1;
              r_timer <= '0;
            end else begin
              r_timer <= r_timer + 1'b1;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end

    assign w_step[g] = r_step;
  end

  logic [CNT_W-1:0] r_count;
  logic [LED_W-1:0] r_leds;
  logic             w_inc, w_dec;

  assign w_inc = w_step[0] & ~w_step[1];
  assign w_dec = w_step[1] & ~w_step[0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (w_inc) begin
      if (!(SAT && r_count == CNT_MAX)) r_count <= r_count + 1'b1;
    end else if (w_dec) begin
      if (!(SAT && r_count == '0)) r_count <= r_count - 1'b1;
    end
  end

  int                     w_cnt_int;
  logic [LED_W+CNT_W-1:0] w_cnt_ext;
  logic [LED_W-1:0]       w_led_pat;

  assign w_cnt_int = int'(r_count);
  assign w_cnt_ext = (LED_W + CNT_W)'(r_count);

  // NOTE: default assignment first keeps this purely combinational (no latch) for every mode.
  always_comb begin
    w_led_pat = '0;
    case (mode)
      2'b00:   for (int i = 0; i < LED_W; i++) w_led_pat[i] = (w_cnt_int == i);
      2'b01:   for (int i = 0; i < LED_W; i++) w_led_pat[i] = (i < w_cnt_int);
      2'b10:   w_led_pat = w_cnt_ext[LED_W-1:0];
      default: w_led_pat = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_leds <= '0;
    else       r_leds <= w_led_pat;
  end

  assign count  = r_count;
  assign LEDS   = r_leds;
  assign at_min = (r_count == '0);
  assign at_max = (r_count == CNT_MAX);

endmodule
